// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared defaults and search FSM encoding for cam_responder
package cam_pkg;

  localparam int KEY_W_DEF   = 32;
  localparam int ENTRIES_DEF = 16;
  localparam int ADDR_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } cam_state_t;

endpackage

// File: rtl/cam_store.sv
// rtl/cam_store.sv - CAM key array with valid bits, one write port and one indexed read port
module cam_store
  import cam_pkg::*;
#(
  parameter int KEY_W   = KEY_W_DEF,
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic              clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [KEY_W-1:0]  rd_key,
  output logic              rd_valid
);

  logic [KEY_W-1:0]   keys_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] valid_d;

  always_comb begin
    valid_d = valid_q;
    if (clr) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Key storage is not reset; only the valid bits decide whether an entry exists.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      keys_q[wr_addr] <= wr_key;
    end
  end

  assign rd_key   = keys_q[rd_addr];
  assign rd_valid = valid_q[rd_addr];

endmodule

// File: rtl/cam_responder.sv
// rtl/cam_responder.sv - sequential CAM search, one entry per cycle; optional cam_clear port under CAM_CLEAR_EN
module cam_responder
  import cam_pkg::*;
#(
  parameter int KEY_W   = KEY_W_DEF,
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cam_write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [KEY_W-1:0]  write_key,
`ifdef CAM_CLEAR_EN
  input  logic              cam_clear,
`endif
  input  logic              cam_start,
  input  logic [KEY_W-1:0]  search_key,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [ADDR_W-1:0] match_addr
);

  cam_state_t        state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              match_q, match_d;
  logic [ADDR_W-1:0] match_addr_q, match_addr_d;

  logic              idle;
  logic              clr_go;
  logic              wr_go;
  logic [KEY_W-1:0]  rd_key;
  logic              rd_valid;
  logic              hit;
  logic              last;

  assign idle = (state_q == ST_IDLE);

`ifdef CAM_CLEAR_EN
  assign clr_go = cam_clear && idle;
`else
  assign clr_go = 1'b0;
`endif

  // A clear wins over a same-cycle write; the array is only touched while idle.
  assign wr_go = cam_write_en && idle && !clr_go;
  assign hit   = rd_valid && (rd_key == key_q);
  assign last  = (idx_q == ADDR_W'(ENTRIES - 1));

  cam_store #(
    .KEY_W   (KEY_W),
    .ENTRIES (ENTRIES),
    .ADDR_W  (ADDR_W)
  ) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_go),
    .wr_addr  (write_addr),
    .wr_key   (write_key),
    .clr      (clr_go),
    .rd_addr  (idx_q),
    .rd_key   (rd_key),
    .rd_valid (rd_valid)
  );

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    idx_d        = idx_q;
    match_d      = match_q;
    match_addr_d = match_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (cam_start) begin
          state_d      = ST_SCAN;
          key_d        = search_key;
          idx_d        = '0;
          match_d      = 1'b0;
          match_addr_d = '0;
        end
      end
      ST_SCAN: begin
        if (hit) begin
          state_d      = ST_DONE;
          match_d      = 1'b1;
          match_addr_d = idx_q;
        end else if (last) begin
          state_d      = ST_DONE;
          match_d      = 1'b0;
          match_addr_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      key_q        <= '0;
      idx_q        <= '0;
      match_q      <= 1'b0;
      match_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      idx_q        <= idx_d;
      match_q      <= match_d;
      match_addr_q <= match_addr_d;
    end
  end

  assign busy       = !idle;
  assign done       = (state_q == ST_DONE);
  assign match      = match_q;
  assign match_addr = match_addr_q;

endmodule
